fuzzy_1: RTL and testbench
==========================

FUZZY_1 -- requirements
Module: fuzzy_1

Interface
- REQ-001: The block SHALL have no parameters; all constants live in the shared package.
- REQ-002: clk_0  input  1  single system clock; all state SHALL update on its rising edge.
- REQ-003: Srst  input  1  reset, asynchronous and active-high.
- REQ-004: Entrada_01  input  8  crisp input A, unsigned 0..255.
- REQ-005: Entrada_02  input  8  crisp input B, unsigned 0..255.
- REQ-006: EN_REGRAS  input  1  rule-engine enable; 0 freezes sequencer, accumulators and output.
- REQ-007: saida_defuzzy  output  8  registered defuzzified crisp output.
- REQ-008: Sclk_int  output  1  clk_0 divided by 2, registered toggle, status only.
- REQ-009: SSequencia_regras  output  4  current sequencer step.
- REQ-010: SReset_Memoria  output  1  high during step 0, when the accumulators clear.
- REQ-011: FOU_ATIVO  output  6  upper-MF-nonzero flags; [2:0] = A Low/Med/High, [5:3] = B Low/Med/High.

Function
- REQ-012: Each input SHALL be fuzzified into 3 interval type-2 trapezoid sets, each with an upper MF and a lower MF (a,b,c,d), grades 0..255.
- REQ-013: Upper MFs SHALL be Low (0,0,64,128), Med (32,96,160,224), High (128,192,255,255); every slope SHALL be 64 wide with grade = min(255, 4*distance).
- REQ-014: Lower MFs SHALL be Low (0,0,48,80), Med (64,96,160,192), High (176,208,255,255); every slope SHALL be 32 wide with grade = min(255, 8*distance).
- REQ-015: Grade SHALL be 0 outside [a,d], 255 in [b,c], rising slope measured from a, falling slope measured from d.
- REQ-016: Rule (i,j), for A set i and B set j, SHALL have upper firing fu = min(uA_i, uB_j) and lower firing fl = min(lA_i, lB_j).
- REQ-017: Rule weight SHALL be w = (fu+fl)>>1.
- REQ-018: Consequent centroids SHALL be: LL 16, LM 48, LH 96, ML 80, MM 128, MH 176, HL 160, HM 208, HH 240.
- REQ-019: Sequencer SHALL count 0..9 and wrap; in step 0 it SHALL sample both inputs, clear the accumulators and assert SReset_Memoria.
- REQ-020: In steps 1..9 the block SHALL process rule k = step-1 in order LL, LM, LH, ML, MM, MH, HL, HM, HH, adding w to den (12 bits) and w*C to num (20 bits), with no overflow possible.
- REQ-021: On the 9->0 wrap, saida_defuzzy SHALL load floor(num/den), or 128 when den = 0.
- REQ-022: Worst-case latency from an input change to a valid output SHALL be 20 clk_0 cycles.
- REQ-023: FOU_ATIVO SHALL be registered from the sampled inputs at step 0.
- REQ-024: With EN_REGRAS = 0 the sequencer, accumulators and saida_defuzzy SHALL hold; Sclk_int SHALL keep toggling.
- REQ-025: When EN_REGRAS rises, processing SHALL continue from the held step.

Reset
- REQ-026: While Srst = 1, saida_defuzzy = 0, SSequencia_regras = 0, Sclk_int = 0, FOU_ATIVO = 0, accumulators = 0, and SReset_Memoria = 1.
- REQ-027: A reset asserted mid-sweep SHALL discard partial sums.
- REQ-028: After release the first sweep SHALL begin at step 0.

Structure
- REQ-029: The package fuzzy_1_pkg SHALL hold the MF breakpoints, centroid table, rule count (9), step width and default output (128).
- REQ-030: A single sub-module it2_trap_mf SHALL compute one set's upper and lower grades; it SHALL be instantiated 6 times.
- REQ-031: The divider SHALL be combinational or multicycle, provided REQ-022 holds.

Verification
- REQ-032: Srst held 65 time units, inputs (1,1) -> saida_defuzzy = 0 during reset, 16 within 20 cycles after release, FOU_ATIVO = 6'b001001.
- REQ-033: Inputs (128,128) -> saida_defuzzy = 128, FOU_ATIVO = 6'b010010.
- REQ-034: Inputs (254,254) -> saida_defuzzy = 240.
- REQ-035: Inputs (64,64) -> weights LL 191, LM 64, ML 64, MM 64 -> num 19440, den 383 -> saida_defuzzy = 50.
- REQ-036: EN_REGRAS = 0 then inputs change from (1,1) to (254,254) -> output stays 16 and SSequencia_regras is frozen; after EN_REGRAS = 1 -> output 240 within 20 cycles.
- REQ-037: Sweep A and B over {1,16,...,240,254} in 17x17 steps, 1000 time units each -> output matches a golden model, Sclk_int period = 2 clk_0 cycles, SReset_Memoria pulses every 10 cycles.

Source files
------------

// File: rtl/fuzzy_1_pkg.sv
// Shared constants for the interval type-2 fuzzy controller.
// Holds the membership breakpoints, consequent centroids, sequencer sizing and the grade helpers.
// Purely declarative: no state and no flow control.
package fuzzy_1_pkg;

  localparam int NUM_RULES = 9;
  localparam int STEP_W    = 4;
  localparam logic [STEP_W-1:0] LAST_STEP = 4'd9;
  localparam logic [7:0] DEFAULT_OUT = 8'd128;

  // Slope gains as shift amounts: upper slopes are 64 wide (x4), lower slopes 32 wide (x8).
  localparam int UPPER_SH = 2;
  localparam int LOWER_SH = 3;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] d;
  } trap_t;

  // Index 0 = Low, 1 = Med, 2 = High; shared by both inputs.
  localparam trap_t UPPER_MF [3] = '{
    '{8'd0,   8'd0,   8'd64,  8'd128},
    '{8'd32,  8'd96,  8'd160, 8'd224},
    '{8'd128, 8'd192, 8'd255, 8'd255}
  };
  localparam trap_t LOWER_MF [3] = '{
    '{8'd0,   8'd0,   8'd48,  8'd80},
    '{8'd64,  8'd96,  8'd160, 8'd192},
    '{8'd176, 8'd208, 8'd255, 8'd255}
  };

  // Rule order LL, LM, LH, ML, MM, MH, HL, HM, HH (A set major, B set minor).
  localparam logic [7:0] CENTROID [NUM_RULES] = '{
    8'd16, 8'd48, 8'd96, 8'd80, 8'd128, 8'd176, 8'd160, 8'd208, 8'd240
  };

  // Trapezoid grade: 0 outside [a,d], 255 on the plateau, saturating slope otherwise.
  function automatic logic [7:0] trap_grade(input logic [7:0] x, input trap_t t, input int sh);
    logic [10:0] g;
    g = '0;
    if (x < t.a || x > t.d) return 8'd0;
    if (x >= t.b && x <= t.c) return 8'hFF;
    if (x < t.b) g = {3'b000, x - t.a};
    else         g = {3'b000, t.d - x};
    g = g << sh;
    return (g > 11'd255) ? 8'hFF : g[7:0];
  endfunction

  function automatic logic [7:0] min8(input logic [7:0] p, input logic [7:0] q);
    return (p < q) ? p : q;
  endfunction

endpackage

// File: rtl/it2_trap_mf.sv
// One interval type-2 trapezoid set: upper and lower membership grades of x.
// Latency: combinational, zero cycles.
// No flow control; output follows x continuously.
module it2_trap_mf
  import fuzzy_1_pkg::*;
#(
  parameter trap_t UPPER = '0,
  parameter trap_t LOWER = '0
) (
  input  logic [7:0] x,
  output logic [7:0] upper,
  output logic [7:0] lower
);

  // Both footprint bounds evaluated in parallel from the same crisp value.
  always_comb begin
    upper = trap_grade(x, UPPER, UPPER_SH);
    lower = trap_grade(x, LOWER, LOWER_SH);
  end

endmodule

// File: rtl/fuzzy_1.sv
// Two-input IT2 fuzzy controller: 10-step sweep (sample/clear, then 9 rules), weighted-centroid output.
// Latency: output updates on the 9->0 wrap; at most 20 cycles from an input change.
// No handshake; EN_REGRAS low freezes the sweep in place and resumes from the held step.
module fuzzy_1
  import fuzzy_1_pkg::*;
(
  input  logic              clk_0,
  input  logic              Srst,
  input  logic [7:0]        Entrada_01,
  input  logic [7:0]        Entrada_02,
  input  logic              EN_REGRAS,
  output logic [7:0]        saida_defuzzy,
  output logic              Sclk_int,
  output logic [STEP_W-1:0] SSequencia_regras,
  output logic              SReset_Memoria,
  output logic [5:0]        FOU_ATIVO
);

  logic [STEP_W-1:0] step;
  logic [7:0]        a_s, b_s;
  logic [19:0]       num, num_nxt;
  logic [11:0]       den, den_nxt;
  logic [7:0]        out_r, out_nxt;
  logic              clk_div;
  logic [5:0]        fou;

  logic [7:0]        mf_a, mf_b;
  logic [7:0]        ua [3];
  logic [7:0]        la [3];
  logic [7:0]        ub [3];
  logic [7:0]        lb [3];
  logic [STEP_W-1:0] ridx;
  logic [1:0]        ai, bj;
  logic [7:0]        fu, fl, w;
  logic [8:0]        w_sum;
  logic [15:0]       prod;

  // Six fuzzifier instances: Low/Med/High for each input.
  for (genvar g = 0; g < 3; g++) begin : g_mf
    it2_trap_mf #(.UPPER(UPPER_MF[g]), .LOWER(LOWER_MF[g])) u_mf_a (
      .x(mf_a), .upper(ua[g]), .lower(la[g])
    );
    it2_trap_mf #(.UPPER(UPPER_MF[g]), .LOWER(LOWER_MF[g])) u_mf_b (
      .x(mf_b), .upper(ub[g]), .lower(lb[g])
    );
  end

  // Rule datapath: pick the rule for this step, fire it, and form the next sums and quotient.
  // In step 0 the fuzzifiers see the live inputs so the active-set flags match what gets sampled.
  always_comb begin
    mf_a = (step == '0) ? Entrada_01 : a_s;
    mf_b = (step == '0) ? Entrada_02 : b_s;
    ridx = (step == '0) ? '0 : step - 4'd1;
    if (ridx < 4'd3) begin
      ai = 2'd0;
      bj = ridx[1:0];
    end else if (ridx < 4'd6) begin
      ai = 2'd1;
      bj = 2'(ridx - 4'd3);
    end else begin
      ai = 2'd2;
      bj = 2'(ridx - 4'd6);
    end
    fu      = min8(ua[ai], ub[bj]);
    fl      = min8(la[ai], lb[bj]);
    w_sum   = {1'b0, fu} + {1'b0, fl};
    w       = w_sum[8:1];
    prod    = w * CENTROID[ridx];
    num_nxt = num + {4'b0000, prod};
    den_nxt = den + {4'b0000, w};
    out_nxt = (den_nxt == '0) ? DEFAULT_OUT : 8'(num_nxt / {8'b0000_0000, den_nxt});
  end

  // Free-running divide-by-two status clock, independent of the enable.
  always_ff @(posedge clk_0 or posedge Srst) begin
    if (Srst) clk_div <= 1'b0;
    else      clk_div <= ~clk_div;
  end

  // Sequencer, sample registers, accumulators and output; all held while the enable is low.
  always_ff @(posedge clk_0 or posedge Srst) begin
    if (Srst) begin
      step  <= '0;
      a_s   <= '0;
      b_s   <= '0;
      num   <= '0;
      den   <= '0;
      out_r <= '0;
      fou   <= '0;
    end else if (EN_REGRAS) begin
      if (step == '0) begin
        a_s  <= Entrada_01;
        b_s  <= Entrada_02;
        num  <= '0;
        den  <= '0;
        fou  <= {|ub[2], |ub[1], |ub[0], |ua[2], |ua[1], |ua[0]};
        step <= 4'd1;
      end else begin
        num <= num_nxt;
        den <= den_nxt;
        if (step == LAST_STEP) begin
          step  <= '0;
          out_r <= out_nxt;
        end else begin
          step <= step + 4'd1;
        end
      end
    end
  end

  assign saida_defuzzy     = out_r;
  assign Sclk_int          = clk_div;
  assign SSequencia_regras = step;
  assign SReset_Memoria    = (step == '0);
  assign FOU_ATIVO         = fou;

endmodule

// File: tb/tb_fuzzy_1.sv
// Directed and swept checks of fuzzy_1 against hand values and an integer reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fuzzy_1;

  logic       clk;
  logic       srst;
  logic [7:0] ent_a, ent_b;
  logic       en;
  logic [7:0] saida;
  logic       sclk;
  logic [3:0] seq;
  logic       srm;
  logic [5:0] fou;

  int checks = 0;
  int errors = 0;

  localparam int U_BP [3][4] = '{'{0, 0, 64, 128}, '{32, 96, 160, 224}, '{128, 192, 255, 255}};
  localparam int L_BP [3][4] = '{'{0, 0, 48, 80}, '{64, 96, 160, 192}, '{176, 208, 255, 255}};
  localparam int CEN  [3][3] = '{'{16, 48, 96}, '{80, 128, 176}, '{160, 208, 240}};

  fuzzy_1 dut (
    .clk_0(clk), .Srst(srst), .Entrada_01(ent_a), .Entrada_02(ent_b), .EN_REGRAS(en),
    .saida_defuzzy(saida), .Sclk_int(sclk), .SSequencia_regras(seq),
    .SReset_Memoria(srm), .FOU_ATIVO(fou)
  );

  // Starts high so falling edges land on odd multiples of 5 and reset releases at t=65 cleanly.
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  function automatic int grade(int x, int a, int b, int c, int d, int k);
    int g;
    if (x < a || x > d) return 0;
    if (x >= b && x <= c) return 255;
    g = (x < b) ? k * (x - a) : k * (d - x);
    return (g > 255) ? 255 : g;
  endfunction

  function automatic int golden_out(int xa, int xb);
    int num, den, fu, fl, uai, ubj, lai, lbj;
    num = 0;
    den = 0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        uai = grade(xa, U_BP[i][0], U_BP[i][1], U_BP[i][2], U_BP[i][3], 4);
        ubj = grade(xb, U_BP[j][0], U_BP[j][1], U_BP[j][2], U_BP[j][3], 4);
        lai = grade(xa, L_BP[i][0], L_BP[i][1], L_BP[i][2], L_BP[i][3], 8);
        lbj = grade(xb, L_BP[j][0], L_BP[j][1], L_BP[j][2], L_BP[j][3], 8);
        fu = (uai < ubj) ? uai : ubj;
        fl = (lai < lbj) ? lai : lbj;
        den += (fu + fl) / 2;
        num += ((fu + fl) / 2) * CEN[i][j];
      end
    end
    return (den == 0) ? 128 : num / den;
  endfunction

  function automatic logic [5:0] golden_fou(int xa, int xb);
    logic [5:0] f;
    for (int i = 0; i < 3; i++) begin
      f[i]     = grade(xa, U_BP[i][0], U_BP[i][1], U_BP[i][2], U_BP[i][3], 4) != 0;
      f[i + 3] = grade(xb, U_BP[i][0], U_BP[i][1], U_BP[i][2], U_BP[i][3], 4) != 0;
    end
    return f;
  endfunction

  function automatic int sweep_val(int n);
    return (n == 0) ? 1 : ((n == 16) ? 254 : 16 * n);
  endfunction

  task automatic wait_out(input logic [7:0] expv);
    for (int n = 0; n < 20 && saida !== expv; n++) @(negedge clk);
  endtask

  task automatic test_reset;
    srst  = 1'b1;
    en    = 1'b1;
    ent_a = 8'd1;
    ent_b = 8'd1;
    repeat (3) @(negedge clk);
    checks++;
    if (saida !== 8'd0 || seq !== 4'd0 || sclk !== 1'b0 || fou !== 6'd0 || srm !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: out=%0d seq=%0d sclk=%b fou=%b srm=%b want 0 0 0 000000 1",
               saida, seq, sclk, fou, srm);
    end
    repeat (4) @(negedge clk);
    srst = 1'b0;
  endtask

  task automatic test_low;
    wait_out(8'd16);
    checks++;
    if (saida !== 8'd16) begin
      errors++;
      $display("FAIL low_out: got %0d want 16", saida);
    end
    checks++;
    if (fou !== 6'b001001) begin
      errors++;
      $display("FAIL low_fou: got %b want 001001", fou);
    end
  endtask

  task automatic test_point(input logic [7:0] xa, input logic [7:0] xb,
                            input logic [7:0] expv, input logic [5:0] expf);
    ent_a = xa;
    ent_b = xb;
    @(negedge clk);
    wait_out(expv);
    repeat (2) @(negedge clk);
    checks++;
    if (saida !== expv) begin
      errors++;
      $display("FAIL point_out(%0d,%0d): got %0d want %0d", xa, xb, saida, expv);
    end
    checks++;
    if (fou !== expf) begin
      errors++;
      $display("FAIL point_fou(%0d,%0d): got %b want %b", xa, xb, fou, expf);
    end
  endtask

  task automatic test_mid_reset;
    ent_a = 8'd128;
    ent_b = 8'd128;
    repeat (15) @(negedge clk);
    srst = 1'b1;
    #1;
    checks++;
    if (saida !== 8'd0 || seq !== 4'd0 || srm !== 1'b1 || fou !== 6'd0) begin
      errors++;
      $display("FAIL mid_reset: out=%0d seq=%0d srm=%b fou=%b want 0 0 1 000000", saida, seq, srm, fou);
    end
    @(negedge clk);
    srst = 1'b0;
    wait_out(8'd128);
    checks++;
    if (saida !== 8'd128) begin
      errors++;
      $display("FAIL after_mid_reset: got %0d want 128", saida);
    end
  endtask

  task automatic test_enable_hold;
    logic s0;
    test_point(8'd1, 8'd1, 8'd16, 6'b001001);
    for (int n = 0; n < 12 && srm !== 1'b1; n++) @(negedge clk);
    repeat (4) @(negedge clk);
    en    = 1'b0;
    ent_a = 8'd254;
    ent_b = 8'd254;
    repeat (30) @(negedge clk);
    checks++;
    if (seq !== 4'd4) begin
      errors++;
      $display("FAIL hold_seq: got %0d want 4", seq);
    end
    checks++;
    if (saida !== 8'd16) begin
      errors++;
      $display("FAIL hold_out: got %0d want 16", saida);
    end
    s0 = sclk;
    @(negedge clk);
    checks++;
    if (sclk !== ~s0) begin
      errors++;
      $display("FAIL hold_sclk: got %b want %b", sclk, ~s0);
    end
    en = 1'b1;
    wait_out(8'd240);
    checks++;
    if (saida !== 8'd240) begin
      errors++;
      $display("FAIL resume_out: got %0d want 240", saida);
    end
  endtask

  task automatic test_timing;
    logic s0;
    int   found;
    found = 0;
    for (int n = 0; n < 12 && found == 0; n++) begin
      @(negedge clk);
      if (srm === 1'b1) found = 1;
    end
    checks++;
    if (found == 0) begin
      errors++;
      $display("FAIL srm_seen: got none want a pulse within 12 cycles");
    end
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      checks++;
      if (srm !== (n == 10)) begin
        errors++;
        $display("FAIL srm_period cycle %0d: got %b want %b", n, srm, (n == 10));
      end
    end
    for (int n = 0; n < 4; n++) begin
      s0 = sclk;
      @(negedge clk);
      checks++;
      if (sclk !== ~s0) begin
        errors++;
        $display("FAIL sclk_toggle %0d: got %b want %b", n, sclk, ~s0);
      end
    end
  endtask

  task automatic test_sweep;
    int xa, xb;
    for (int i = 0; i < 17; i++) begin
      for (int j = 0; j < 17; j++) begin
        xa = sweep_val(i);
        xb = sweep_val(j);
        ent_a = 8'(xa);
        ent_b = 8'(xb);
        repeat (100) @(negedge clk);
        checks++;
        if (saida !== 8'(golden_out(xa, xb)) || fou !== golden_fou(xa, xb)) begin
          errors++;
          $display("FAIL sweep(%0d,%0d): out=%0d fou=%b want %0d %b",
                   xa, xb, saida, fou, golden_out(xa, xb), golden_fou(xa, xb));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_low();
    test_point(8'd128, 8'd128, 8'd128, 6'b010010);
    test_point(8'd254, 8'd254, 8'd240, 6'b100100);
    test_point(8'd64, 8'd64, 8'd50, 6'b011011);
    test_mid_reset();
    test_enable_hold();
    test_timing();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
